// File: rtl/logicprobe_pkg.sv
// Shared constants and types for the logic-probe serial dump link.
// Used by the transmitter, the sampler and the receive side.
package logicprobe_pkg;

    localparam int unsigned LP_CLKS_PER_BIT = 1303;
    localparam int unsigned LP_WORD_BYTES   = 16;
    localparam int unsigned LP_TRACE_WORDS  = 512;
    localparam int unsigned LP_CHANNELS     = 128;

    // One channel sample; channel 127 sits in the MSB.
    typedef logic [LP_CHANNELS-1:0] lp_word_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/logicprobe_uart_rx.sv
// 8N1 byte receiver: input synchroniser, bit FSM, byte strobe and sticky framing error.
// With LOGICPROBE_RCV_TIMEOUT_EN an idle indication is exported for word resync.
import logicprobe_pkg::*;

module logicprobe_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = LP_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_serial_in,
`ifdef LOGICPROBE_RCV_TIMEOUT_EN
    output logic       o_rx_idle_c,
`endif
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_LOAD = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_LOAD = CLKS_PER_BIT - 1;

    rx_state_t        r_state, w_state_d;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [2:0]       r_bit_idx, w_bit_idx_d;
    logic [7:0]       r_shift, w_shift_d;
    logic             r_armed, w_armed_d;
    logic             r_byte_valid, w_byte_valid_d;
    logic [7:0]       r_byte_data, w_byte_data_d;
    logic             r_frame_err, w_frame_err_d;
    logic             w_s;

    assign w_s = r_sync[1];

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RX_IDLE;
            r_sync       <= 2'b11;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_armed      <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_sync       <= {r_sync[0], i_serial_in};
            r_cnt        <= w_cnt_d;
            r_bit_idx    <= w_bit_idx_d;
            r_shift      <= w_shift_d;
            r_armed      <= w_armed_d;
            r_byte_valid <= w_byte_valid_d;
            r_byte_data  <= w_byte_data_d;
            r_frame_err  <= w_frame_err_d;
        end
    end

    // Next-state and outputs; r_armed blocks re-triggering on a line held low
    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_bit_idx_d    = r_bit_idx;
        w_shift_d      = r_shift;
        w_armed_d      = r_armed;
        w_byte_valid_d = 1'b0;
        w_byte_data_d  = r_byte_data;
        w_frame_err_d  = r_frame_err;
        case (r_state)
            RX_IDLE: begin
                if (!r_armed) begin
                    w_armed_d = w_s;
                end else if (!w_s) begin
                    w_armed_d = 1'b0;
                    w_cnt_d   = CNT_W'(HALF_LOAD);
                    w_state_d = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == '0) begin
                    if (!w_s) begin
                        w_cnt_d     = CNT_W'(FULL_LOAD);
                        w_bit_idx_d = '0;
                        w_state_d   = RX_DATA;
                    end else begin
                        w_state_d = RX_IDLE;
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_d = {w_s, r_shift[7:1]};
                    w_cnt_d   = CNT_W'(FULL_LOAD);
                    if (r_bit_idx == 3'd7) begin
                        w_state_d = RX_STOP;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_cnt == '0) begin
                    if (w_s) begin
                        w_byte_valid_d = 1'b1;
                        w_byte_data_d  = r_shift;
                    end else begin
                        w_frame_err_d = 1'b1;
                    end
                    w_state_d = RX_IDLE;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_d = RX_IDLE;
            end
        endcase
    end

`ifdef LOGICPROBE_RCV_TIMEOUT_EN
    assign o_rx_idle_c = (r_state == RX_IDLE);
`endif
    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/logicprobe_rcv.sv
// Logic-probe dump receiver: bytes -> 128-bit samples with valid/ready handoff and trace counting.
// Define LOGICPROBE_RCV_TIMEOUT_EN to drop a partial word after a long idle gap.
import logicprobe_pkg::*;

module logicprobe_rcv #(
    parameter int unsigned CLKS_PER_BIT    = LP_CLKS_PER_BIT,
`ifdef LOGICPROBE_RCV_TIMEOUT_EN
    parameter int unsigned TIMEOUT_BITS    = 20,
`endif
    parameter int unsigned WORDS_PER_TRACE = LP_TRACE_WORDS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_serial_in,
    output logic                   o_byte_valid,
    output logic [7:0]             o_byte_data,
    output logic                   o_word_valid,
    input  logic                   i_word_ready,
    output logic [LP_CHANNELS-1:0] o_word_data,
    output logic [8:0]             o_word_index,
    output logic                   o_done,
    output logic                   o_frame_err,
    output logic                   o_overrun
);

    localparam int unsigned BYTES_PER_WORD = LP_WORD_BYTES;
    localparam int unsigned ASSY_W         = (BYTES_PER_WORD - 1) * 8;
    localparam int unsigned BCNT_W         = 4;
    localparam int unsigned IDX_W          = 9;

    logic              w_byte_valid;
    logic [7:0]        w_byte_data;
    logic              w_frame_err;
    logic              w_timeout;
    logic              w_accept;
    logic              w_last_accept;
    logic              w_word_complete;
    logic              w_load;
    logic              w_overrun;

    logic [ASSY_W-1:0] r_assy;
    logic [BCNT_W-1:0] r_byte_cnt;
    lp_word_t          r_word_data;
    logic              r_word_valid;
    logic [IDX_W-1:0]  r_word_cnt;
    logic              r_done;
    logic              r_overrun;

`ifdef LOGICPROBE_RCV_TIMEOUT_EN
    logic w_rx_idle;
`endif

    logicprobe_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clock        (clock),
        .reset        (reset),
        .i_serial_in  (i_serial_in),
`ifdef LOGICPROBE_RCV_TIMEOUT_EN
        .o_rx_idle_c  (w_rx_idle),
`endif
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err)
    );

    // Handshake decode; an accept in the completion cycle frees the holding register
    always_comb begin
        w_accept        = r_word_valid && i_word_ready;
        w_last_accept   = w_accept && (r_word_cnt == IDX_W'(WORDS_PER_TRACE - 1));
        w_word_complete = w_byte_valid && !r_done &&
                          (r_byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
        w_load          = w_word_complete && (!r_word_valid || w_accept) && !w_last_accept;
        w_overrun       = w_word_complete && r_word_valid && !w_accept;
    end

`ifdef LOGICPROBE_RCV_TIMEOUT_EN
    localparam int unsigned IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_idle_run;

    assign w_idle_run = w_rx_idle && (r_byte_cnt != '0) && !w_byte_valid;
    assign w_timeout  = w_idle_run && (r_idle_cnt >= IDLE_W'(IDLE_LIMIT));

    // Idle gap counter while a partial word is pending
    always_ff @(posedge clock) begin
        if (reset || !w_idle_run || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Byte assembly, word holding register and trace counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_assy       <= '0;
            r_byte_cnt   <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_word_cnt   <= '0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_byte_valid && !r_done) begin
                r_assy     <= {r_assy[ASSY_W-9:0], w_byte_data};
                r_byte_cnt <= w_word_complete ? '0 : r_byte_cnt + BCNT_W'(1);
            end else if (w_timeout) begin
                r_byte_cnt <= '0;
            end

            if (w_load) begin
                r_word_data  <= {r_assy, w_byte_data};
                r_word_valid <= 1'b1;
            end else if (w_accept) begin
                r_word_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_last_accept) begin
                    r_done <= 1'b1;
                end else begin
                    r_word_cnt <= r_word_cnt + IDX_W'(1);
                end
            end

            if (w_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_byte_valid = w_byte_valid;
    assign o_byte_data  = w_byte_data;
    assign o_frame_err  = w_frame_err;
    assign o_word_valid = r_word_valid;
    assign o_word_data  = r_word_data;
    assign o_word_index = r_word_cnt;
    assign o_done       = r_done;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_logicprobe_rcv.sv
// Directed bench for logicprobe_rcv at a short bit period and a 4-word trace.
// Timeout scenario runs only when LOGICPROBE_RCV_TIMEOUT_EN is defined.
module tb_logicprobe_rcv;

    localparam int unsigned CPB   = 16;
    localparam int unsigned TRACE = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         i_serial_in;
    logic         i_word_ready;
    logic         o_byte_valid;
    logic [7:0]   o_byte_data;
    logic         o_word_valid;
    logic [127:0] o_word_data;
    logic [8:0]   o_word_index;
    logic         o_done;
    logic         o_frame_err;
    logic         o_overrun;

    int checks   = 0;
    int failures = 0;

    int           bv_cnt    = 0;
    int           wv_cycles = 0;
    logic [7:0]   last_byte = 8'h00;
    logic [127:0] acc_data[$];
    logic [8:0]   acc_idx[$];

    logicprobe_rcv #(
        .CLKS_PER_BIT    (CPB),
        .WORDS_PER_TRACE (TRACE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_serial_in  (i_serial_in),
        .o_byte_valid (o_byte_valid),
        .o_byte_data  (o_byte_data),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_word_data  (o_word_data),
        .o_word_index (o_word_index),
        .o_done       (o_done),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun)
    );

    always #5 clock = ~clock;

    // Observe strobes and accepted words away from the active edge
    always @(negedge clock) begin
        if (o_byte_valid) begin
            bv_cnt    <= bv_cnt + 1;
            last_byte <= o_byte_data;
        end
        if (o_word_valid) begin
            wv_cycles <= wv_cycles + 1;
        end
        if (o_word_valid && i_word_ready) begin
            acc_data.push_back(o_word_data);
            acc_idx.push_back(o_word_index);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        i_serial_in = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            i_serial_in = b[i];
            wait_cyc(CPB);
        end
        i_serial_in = stop_bit;
        wait_cyc(CPB);
        i_serial_in = 1'b1;
        wait_cyc(2);
    endtask

    task automatic send_word(input logic [7:0] base);
        for (int j = 0; j < 16; j++) begin
            send_byte(base + 8'(j), 1'b1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
    endtask

    function automatic logic [127:0] make_word(input logic [7:0] base);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) begin
            w = {w[119:0], base + 8'(j)};
        end
        return w;
    endfunction

    initial begin
        int b0;
        int w0;
        int a0;

        reset        = 1'b1;
        i_serial_in  = 1'b1;
        i_word_ready = 1'b0;
        wait_cyc(1);
        do_reset();

        // Reset state
        check("rst_byte_valid", 128'(o_byte_valid), 128'd0);
        check("rst_byte_data",  128'(o_byte_data),  128'd0);
        check("rst_word_valid", 128'(o_word_valid), 128'd0);
        check("rst_word_data",  o_word_data,        128'd0);
        check("rst_word_index", 128'(o_word_index), 128'd0);
        check("rst_done",       128'(o_done),       128'd0);
        check("rst_frame_err",  128'(o_frame_err),  128'd0);
        check("rst_overrun",    128'(o_overrun),    128'd0);

        // Single byte decode
        b0 = bv_cnt;
        send_byte(8'hA5, 1'b1);
        check("a5_pulses",    128'(bv_cnt - b0), 128'd1);
        check("a5_data",      128'(last_byte),   128'hA5);
        check("a5_frame_err", 128'(o_frame_err), 128'd0);

        // First word, ready held high
        do_reset();
        i_word_ready = 1'b1;
        w0 = wv_cycles;
        a0 = acc_data.size();
        send_word(8'h00);
        check("w0_valid_cycles", 128'(wv_cycles - w0),          128'd1);
        check("w0_accepts",      128'(acc_data.size() - a0),    128'd1);
        check("w0_data",         acc_data[a0], 128'h000102030405060708090A0B0C0D0E0F);
        check("w0_index",        128'(acc_idx[a0]),             128'd0);
        check("w0_valid_low",    128'(o_word_valid),            128'd0);

        // Rest of the trace, then one extra byte after done
        a0 = acc_data.size();
        for (int k = 1; k < TRACE; k++) begin
            send_word(8'(k * 16));
        end
        check("trace_accepts", 128'(acc_data.size() - a0), 128'(TRACE - 1));
        for (int k = 1; k < TRACE; k++) begin
            check("trace_index", 128'(acc_idx[a0 + k - 1]), 128'(k));
            check("trace_data",  acc_data[a0 + k - 1],     make_word(8'(k * 16)));
        end
        check("trace_done", 128'(o_done), 128'd1);
        b0 = bv_cnt;
        w0 = wv_cycles;
        send_byte(8'h55, 1'b1);
        check("post_done_byte",   128'(bv_cnt - b0),     128'd1);
        check("post_done_data",   128'(last_byte),       128'h55);
        check("post_done_nowv",   128'(wv_cycles - w0),  128'd0);
        check("post_done_index",  128'(o_word_index),    128'(TRACE - 1));

        // Overrun: two words with nobody accepting
        do_reset();
        i_word_ready = 1'b0;
        send_word(8'h20);
        send_word(8'h40);
        check("ovr_flag",  128'(o_overrun),    128'd1);
        check("ovr_valid", 128'(o_word_valid), 128'd1);
        check("ovr_index", 128'(o_word_index), 128'd0);
        check("ovr_data",  o_word_data,        make_word(8'h20));
        a0 = acc_data.size();
        @(posedge clock);
        #1 i_word_ready = 1'b1;
        wait_cyc(2);
        check("ovr_accepts",   128'(acc_data.size() - a0), 128'd1);
        check("ovr_acc_index", 128'(acc_idx[a0]),          128'd0);
        check("ovr_valid_low", 128'(o_word_valid),         128'd0);

        // Framing error, start glitch, then recovery
        do_reset();
        b0 = bv_cnt;
        send_byte(8'h3C, 1'b0);
        check("ferr_flag",  128'(o_frame_err),  128'd1);
        check("ferr_nobyte", 128'(bv_cnt - b0), 128'd0);
        wait_cyc(CPB);
        b0 = bv_cnt;
        i_serial_in = 1'b0;
        wait_cyc(CPB / 4);
        i_serial_in = 1'b1;
        wait_cyc(3 * CPB);
        check("glitch_nobyte", 128'(bv_cnt - b0), 128'd0);
        send_byte(8'h5A, 1'b1);
        check("glitch_recover", 128'(bv_cnt - b0), 128'd1);
        check("glitch_data",    128'(last_byte),    128'h5A);

        // Reset mid-word discards the partial bytes
        do_reset();
        for (int j = 0; j < 7; j++) begin
            send_byte(8'hEE, 1'b1);
        end
        do_reset();
        a0 = acc_data.size();
        send_word(8'h80);
        check("rstmid_accepts", 128'(acc_data.size() - a0), 128'd1);
        check("rstmid_index",   128'(acc_idx[a0]),          128'd0);
        check("rstmid_data",    acc_data[a0],               make_word(8'h80));

`ifdef LOGICPROBE_RCV_TIMEOUT_EN
        // Long gap after a partial word resynchronises assembly
        do_reset();
        for (int j = 0; j < 5; j++) begin
            send_byte(8'h99, 1'b1);
        end
        wait_cyc(21 * CPB);
        a0 = acc_data.size();
        send_word(8'hC0);
        check("tmo_accepts", 128'(acc_data.size() - a0), 128'd1);
        check("tmo_index",   128'(acc_idx[a0]),          128'd0);
        check("tmo_data",    acc_data[a0],               make_word(8'hC0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
